// File: rtl/ct_pkg.sv
// Shared definitions for the ct_merge_rs stream merge.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
//
// Contents: arbitration-mode constants, grant-lock state encoding, a
// bit-width helper used to size the source index, and the skid-entry width.
package ct_pkg;

  localparam int MODE_RR    = 0;
  localparam int MODE_FIXED = 1;

  // Grant lock: OPEN re-arbitrates every beat, LOCK holds the grant until eop.
  typedef enum logic {
    ARB_OPEN = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_t;

  // Number of bits needed to represent 'value' (0 -> 0, 1 -> 1, 2..3 -> 2, ...).
  function automatic int CLogB2(input int value);
    int n;
    int v;
    n = 0;
    v = value;
    while (v > 0) begin
      n++;
      v = v >> 1;
    end
    return n;
  endfunction

  // Source-index width: enough for NI-1, never narrower than one bit.
  function automatic int ct_nibits(input int ni);
    int b;
    b = CLogB2(ni - 1);
    return (b < 1) ? 1 : b;
  endfunction

  // Width of one packed skid entry {data, eop, src}.
  function automatic int ct_ent_bits(input int width, input int nibits);
    return width + 1 + nibits;
  endfunction

endpackage

// File: rtl/ct_merge_rs_if.sv
// Bundle of the merge's upstream (N streams) and downstream (1 stream) signals.
// Latency: n/a (wires only).
// Backpressure: o_ready per upstream stream, i_ready from the downstream consumer.
//
// Ports: i_data/i_valid/i_eop in, o_ready out (upstream side);
//        o_data/o_valid/o_eop/o_src out, i_ready in (downstream side).
// slave = the merge block, master = the environment driving it.
interface ct_merge_rs_if #(
  parameter int NI    = 2,
  parameter int WIDTH = 32
);
  import ct_pkg::*;

  localparam int NIBITS = ct_nibits(NI);

  logic [NI*WIDTH-1:0] i_data;
  logic [NI-1:0]       i_valid;
  logic [NI-1:0]       i_eop;
  logic [NI-1:0]       o_ready;
  logic [WIDTH-1:0]    o_data;
  logic                o_valid;
  logic                o_eop;
  logic [NIBITS-1:0]   o_src;
  logic                i_ready;

  modport slave (
    input  i_data, i_valid, i_eop, i_ready,
    output o_ready, o_data, o_valid, o_eop, o_src
  );

  modport master (
    output i_data, i_valid, i_eop, i_ready,
    input  o_ready, o_data, o_valid, o_eop, o_src
  );

endinterface

// File: rtl/ct_skid_buf.sv
// Two-entry registered output stage: a main register that drives the outputs plus one skid slot.
// Latency: 1 cycle from in_valid&&in_ready to out_valid.
// Backpressure: in_ready = !skid_valid, so it is registered and never depends on out_ready.
//
// Ports: clk, reset_n (async active-low); in_valid/in_ready/in_data (W bits) from the producer;
//        out_valid/out_ready/out_data (W bits) to the consumer.
module ct_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_vld;
  logic         skid_vld;
  logic [W-1:0] main_dat;
  logic [W-1:0] skid_dat;
  logic         acc;
  logic         drain;

  assign in_ready  = !skid_vld;
  assign out_valid = main_vld;
  assign out_data  = main_dat;

  assign acc   = in_valid && !skid_vld;
  assign drain = main_vld && out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      main_dat <= '0;
      skid_dat <= '0;
    end else if (skid_vld) begin
      // Skid full means in_ready was low, so no new beat can arrive this cycle.
      if (drain) begin
        main_dat <= skid_dat;
        skid_vld <= 1'b0;
      end
    end else if (acc) begin
      // Main is free either because it is empty or because it drains this cycle.
      if (!main_vld || out_ready) begin
        main_dat <= in_data;
        main_vld <= 1'b1;
      end else begin
        skid_dat <= in_data;
        skid_vld <= 1'b1;
      end
    end else if (drain) begin
      main_vld <= 1'b0;
    end
  end

endmodule

// File: rtl/ct_merge_rs.sv
// Packet-aware NI-to-1 stream merge (round-robin or fixed priority) with a registered skid output.
// Latency: 1 cycle from the accepting edge to the beat on o_*.
// Backpressure: o_ready depends only on i_valid and registered state; i_ready only drains the skid stage.
//
// Ports: clk, reset_n (async active-low); bus (ct_merge_rs_if.slave):
//   i_data[NI*WIDTH], i_valid[NI], i_eop[NI] in, o_ready[NI] out (at most one bit set);
//   o_data[WIDTH], o_valid, o_eop, o_src[NIBITS] out (registered), i_ready in.
module ct_merge_rs
  import ct_pkg::*;
#(
  parameter int NI       = 2,
  parameter int WIDTH    = 32,
  parameter int MODE     = 0,
  parameter int PKT_LOCK = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  ct_merge_rs_if.slave  bus
);

  localparam int NIBITS = ct_nibits(NI);
  localparam int EBITS  = ct_ent_bits(WIDTH, NIBITS);

  typedef struct packed {
    logic [WIDTH-1:0]  data;
    logic              eop;
    logic [NIBITS-1:0] src;
  } ent_t;

  arb_state_t        state;
  arb_state_t        state_nxt;
  logic              locked;
  logic [NIBITS-1:0] last;
  logic [NIBITS-1:0] lock_src;
  logic [NIBITS-1:0] grant;
  logic [NIBITS-1:0] cand;
  logic              found;
  logic              can_accept;
  logic              accept;
  logic [NI-1:0]     rdy;
  logic [WIDTH-1:0]  sel_data;
  logic              sel_eop;
  ent_t              in_ent;
  ent_t              out_ent;
  logic [EBITS-1:0]  out_bits;
  logic              out_vld;

  assign locked = (state == ARB_LOCK);

  // Grant selection. Round-robin starts scanning just after the last winner and
  // ends on it, so the previous winner has the lowest priority.
  always_comb begin
    grant = last;
    cand  = '0;
    found = 1'b0;
    if (locked) begin
      grant = lock_src;
    end else if (MODE == MODE_FIXED) begin
      for (int i = 0; i < NI; i++) begin
        if (!found && bus.i_valid[i]) begin
          grant = NIBITS'(i);
          found = 1'b1;
        end
      end
    end else begin
      for (int k = 1; k <= NI; k++) begin
        cand = NIBITS'((int'(last) + k) % NI);
        if (!found && bus.i_valid[cand]) begin
          grant = cand;
          found = 1'b1;
        end
      end
    end
  end

  // Ready fan-out and data mux. Gating with reset_n keeps o_ready low while in reset.
  always_comb begin
    rdy      = '0;
    sel_data = '0;
    sel_eop  = 1'b0;
    for (int i = 0; i < NI; i++) begin
      if (grant == NIBITS'(i)) begin
        sel_data = bus.i_data[i*WIDTH +: WIDTH];
        sel_eop  = bus.i_eop[i];
        rdy[i]   = can_accept && bus.i_valid[i] && reset_n;
      end
    end
  end

  assign accept      = |rdy;
  assign bus.o_ready = rdy;

  // Lock FSM: a non-eop beat opens a packet (when packet locking is on), an eop beat closes it.
  always_comb begin
    state_nxt = state;
    if (accept) begin
      if (sel_eop) begin
        state_nxt = ARB_OPEN;
      end else if (PKT_LOCK != 0) begin
        state_nxt = ARB_LOCK;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ARB_OPEN;
    end else begin
      state <= state_nxt;
    end
  end

  // last resets to NI-1 so that stream 0 is first in round-robin order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last     <= NIBITS'(NI - 1);
      lock_src <= '0;
    end else if (accept) begin
      last <= grant;
      if (!sel_eop && (PKT_LOCK != 0)) begin
        lock_src <= grant;
      end
    end
  end

  assign in_ent.data = sel_data;
  assign in_ent.eop  = sel_eop;
  assign in_ent.src  = grant;

  ct_skid_buf #(
    .W (EBITS)
  ) u_skid (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (accept),
    .in_ready  (can_accept),
    .in_data   (in_ent),
    .out_valid (out_vld),
    .out_ready (bus.i_ready),
    .out_data  (out_bits)
  );

  assign out_ent     = ent_t'(out_bits);
  assign bus.o_valid = out_vld;
  assign bus.o_data  = out_ent.data;
  assign bus.o_eop   = out_ent.eop;
  assign bus.o_src   = out_ent.src;

endmodule

// File: tb/tb_ct_merge_rs.sv
// Scoreboard bench for ct_merge_rs: three instances (3-way round-robin with
// packet lock, 3-way fixed priority per beat, single input) share clk/reset_n.
module tb_ct_merge_rs;

  typedef struct packed {
    logic [15:0] data;
    logic        eop;
  } beat_t;

  typedef struct packed {
    logic [15:0] data;
    logic        eop;
    logic [1:0]  src;
  } exp_t;

  logic clk;
  logic reset_n;

  int total = 0;
  int bad   = 0;

  // Upstream beat queues: 0..2 -> rr streams, 3..5 -> fx streams, 6 -> single.
  beat_t txq[7][$];
  bit    gate[7] = '{1, 1, 1, 1, 1, 1, 1};
  exp_t  exp_rr[$];
  exp_t  exp_fx[$];
  exp_t  exp_one[$];

  ct_merge_rs_if #(.NI(3), .WIDTH(16)) rr_if ();
  ct_merge_rs_if #(.NI(3), .WIDTH(16)) fx_if ();
  ct_merge_rs_if #(.NI(1), .WIDTH(16)) one_if ();

  ct_merge_rs #(.NI(3), .WIDTH(16), .MODE(0), .PKT_LOCK(1)) u_rr (
    .clk(clk), .reset_n(reset_n), .bus(rr_if.slave));
  ct_merge_rs #(.NI(3), .WIDTH(16), .MODE(1), .PKT_LOCK(0)) u_fx (
    .clk(clk), .reset_n(reset_n), .bus(fx_if.slave));
  ct_merge_rs #(.NI(1), .WIDTH(16), .MODE(0), .PKT_LOCK(1)) u_one (
    .clk(clk), .reset_n(reset_n), .bus(one_if.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h @%0t", nm, act, req, $time);
    end
  endtask

  task automatic tx(int s, logic [15:0] d, logic e);
    beat_t b;
    b.data = d;
    b.eop  = e;
    txq[s].push_back(b);
  endtask

  task automatic ex(int which, logic [15:0] d, logic e, logic [1:0] src);
    exp_t x;
    x.data = d;
    x.eop  = e;
    x.src  = src;
    case (which)
      0:       exp_rr.push_back(x);
      1:       exp_fx.push_back(x);
      default: exp_one.push_back(x);
    endcase
  endtask

  function automatic beat_t hd(int s);
    if (txq[s].size() > 0) return txq[s][0];
    return '0;
  endfunction

  function automatic logic vis(int s);
    return (txq[s].size() > 0) && gate[s];
  endfunction

  task automatic drive_all();
    beat_t b;
    for (int s = 0; s < 3; s++) begin
      b = hd(s);
      rr_if.i_valid[s]          = vis(s);
      rr_if.i_data[s*16 +: 16]  = b.data;
      rr_if.i_eop[s]            = b.eop;
      b = hd(s + 3);
      fx_if.i_valid[s]          = vis(s + 3);
      fx_if.i_data[s*16 +: 16]  = b.data;
      fx_if.i_eop[s]            = b.eop;
    end
    b = hd(6);
    one_if.i_valid[0] = vis(6);
    one_if.i_data     = b.data;
    one_if.i_eop[0]   = b.eop;
  endtask

  // Upstream driver: a beat whose o_ready was seen mid-cycle is consumed at the edge.
  initial begin
    bit take[7];
    drive_all();
    forever begin
      @(negedge clk);
      for (int s = 0; s < 3; s++) begin
        take[s]     = rr_if.o_ready[s];
        take[s + 3] = fx_if.o_ready[s];
      end
      take[6] = one_if.o_ready[0];
      @(posedge clk);
      #1;
      for (int s = 0; s < 7; s++)
        if (take[s] && txq[s].size() > 0) void'(txq[s].pop_front());
      drive_all();
    end
  end

  task automatic cmp(string nm, int which, exp_t act);
    exp_t e;
    int   sz;
    case (which)
      0:       sz = exp_rr.size();
      1:       sz = exp_fx.size();
      default: sz = exp_one.size();
    endcase
    if (sz == 0) begin
      total++;
      bad++;
      $display("FAIL %s unexpected beat actual=%h required=none", nm, act);
    end else begin
      case (which)
        0:       e = exp_rr.pop_front();
        1:       e = exp_fx.pop_front();
        default: e = exp_one.pop_front();
      endcase
      chk(nm, 32'(act), 32'(e));
    end
  endtask

  // Monitor: every downstream transfer is popped against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        chk("rr_rdy_onehot", 32'($onehot0(rr_if.o_ready)), 32'd1);
        chk("fx_rdy_onehot", 32'($onehot0(fx_if.o_ready)), 32'd1);
        if (rr_if.o_valid && rr_if.i_ready)
          cmp("rr_beat", 0, exp_t'({rr_if.o_data, rr_if.o_eop, rr_if.o_src}));
        if (fx_if.o_valid && fx_if.i_ready)
          cmp("fx_beat", 1, exp_t'({fx_if.o_data, fx_if.o_eop, fx_if.o_src}));
        if (one_if.o_valid && one_if.i_ready)
          cmp("one_beat", 2, exp_t'({one_if.o_data, one_if.o_eop, 1'b0, one_if.o_src}));
      end
    end
  end

  function automatic bit busy();
    for (int s = 0; s < 7; s++) if (txq[s].size() > 0) return 1'b1;
    return (exp_rr.size() + exp_fx.size() + exp_one.size()) != 0;
  endfunction

  task automatic wait_empty(string nm, int budget);
    int n;
    n = 0;
    while (n < budget && busy()) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    chk(nm, 32'(exp_rr.size() + exp_fx.size() + exp_one.size()), 32'd0);
  endtask

  initial begin
    logic [15:0] d;
    reset_n        = 1'b0;
    rr_if.i_ready  = 1'b1;
    fx_if.i_ready  = 1'b1;
    one_if.i_ready = 1'b1;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rr_valid", 32'(rr_if.o_valid), 32'd0);
    chk("rst_rr_data",  32'(rr_if.o_data),  32'd0);
    chk("rst_rr_src",   32'(rr_if.o_src),   32'd0);
    chk("rst_rr_eop",   32'(rr_if.o_eop),   32'd0);
    chk("rst_fx_valid", 32'(fx_if.o_valid), 32'd0);
    chk("rst_one_valid", 32'(one_if.o_valid), 32'd0);
    reset_n = 1'b1;

    // 1: round-robin, 2-beat packets from all three streams.
    @(posedge clk);
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < 3; s++)
        for (int b = 0; b < 2; b++) begin
          d = 16'h1000 + 16'(s * 256 + p * 16 + b);
          tx(s, d, b == 1);
        end
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < 3; s++)
        for (int b = 0; b < 2; b++) begin
          d = 16'h1000 + 16'(s * 256 + p * 16 + b);
          ex(0, d, b == 1, 2'(s));
        end
    @(negedge clk);
    chk("t1_first_rdy",   32'(rr_if.o_ready), 32'b001);
    chk("t1_no_out_yet",  32'(rr_if.o_valid), 32'd0);
    @(negedge clk);
    chk("t1_out_after_1", 32'(rr_if.o_valid), 32'd1);
    wait_empty("t1_drain", 60);

    // 2: fixed priority, per-beat arbitration; stream 0 runs dry after 4 beats.
    @(posedge clk);
    for (int b = 0; b < 4; b++) begin
      tx(3, 16'h2000 + 16'(b), 1'b1);
      tx(5, 16'h2200 + 16'(b), 1'b1);
    end
    for (int b = 0; b < 4; b++) ex(1, 16'h2000 + 16'(b), 1'b1, 2'd0);
    for (int b = 0; b < 4; b++) ex(1, 16'h2200 + 16'(b), 1'b1, 2'd2);
    @(negedge clk);
    chk("t2_rdy_low_wins", 32'(fx_if.o_ready), 32'b001);
    wait_empty("t2_drain", 40);

    // 3: back-pressure on a single stream A,B,C,D.
    @(posedge clk);
    tx(0, 16'h000A, 1'b0);
    tx(0, 16'h000B, 1'b0);
    tx(0, 16'h000C, 1'b0);
    tx(0, 16'h000D, 1'b1);
    ex(0, 16'h000A, 1'b0, 2'd0);
    ex(0, 16'h000B, 1'b0, 2'd0);
    ex(0, 16'h000C, 1'b0, 2'd0);
    ex(0, 16'h000D, 1'b1, 2'd0);
    @(posedge clk);
    #2 rr_if.i_ready = 1'b0;
    @(negedge clk);
    chk("t3_rdy_into_skid", 32'(rr_if.o_ready), 32'b001);
    chk("t3_hold_a0",       32'(rr_if.o_data),  32'h000A);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("t3_hold_a",      32'(rr_if.o_data),  32'h000A);
      chk("t3_rdy_skidful", 32'(rr_if.o_ready), 32'b000);
    end
    @(posedge clk);
    #2 rr_if.i_ready = 1'b1;
    @(negedge clk);
    chk("t3_rdy_while_drain", 32'(rr_if.o_ready), 32'b000);
    @(negedge clk);
    chk("t3_rdy_back",  32'(rr_if.o_ready), 32'b001);
    chk("t3_b_in_main", 32'(rr_if.o_data),  32'h000B);
    wait_empty("t3_drain", 30);

    // 4: stream 1 packet locks out stream 0 until its eop.
    @(posedge clk);
    for (int b = 0; b < 4; b++) begin
      tx(1, 16'h4100 + 16'(b), b == 3);
      ex(0, 16'h4100 + 16'(b), b == 3, 2'd1);
    end
    ex(0, 16'h4000, 1'b1, 2'd0);
    @(posedge clk);
    tx(0, 16'h4000, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t4_locked_rdy", 32'(rr_if.o_ready), 32'b010);
    end
    @(negedge clk);
    chk("t4_next_grant", 32'(rr_if.o_ready), 32'b001);
    wait_empty("t4_drain", 30);

    // 5: reset in the middle of a stream 1 packet.
    @(posedge clk);
    for (int b = 0; b < 4; b++) tx(1, 16'h5100 + 16'(b), b == 3);
    ex(0, 16'h5100, 1'b0, 2'd1);
    @(posedge clk);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(rr_if.o_valid), 32'd0);
    chk("t5_rst_rdy",   32'(rr_if.o_ready), 32'd0);
    chk("t5_rst_src",   32'(rr_if.o_src),   32'd0);
    for (int s = 0; s < 7; s++) txq[s].delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    tx(0, 16'h5200, 1'b1);
    tx(1, 16'h5300, 1'b1);
    ex(0, 16'h5200, 1'b1, 2'd0);
    ex(0, 16'h5300, 1'b1, 2'd1);
    @(negedge clk);
    chk("t5_s0_wins", 32'(rr_if.o_ready), 32'b001);
    wait_empty("t5_drain", 30);

    // 6: single input, random valid and ready.
    @(posedge clk);
    for (int i = 0; i < 40; i++) begin
      d = 16'($urandom);
      tx(6, d, 1'($urandom_range(0, 1)));
      ex(2, d, txq[6][i].eop, 2'd0);
    end
    for (int c = 0; c < 300; c++) begin
      @(posedge clk);
      gate[6] = 1'($urandom_range(0, 1));
      #2 one_if.i_ready = 1'($urandom_range(0, 1));
    end
    @(posedge clk);
    gate[6] = 1'b1;
    #2 one_if.i_ready = 1'b1;
    wait_empty("t6_drain", 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
